uart_rx: RTL and testbench

16x-oversampling UART receiver consuming the one-cycle `tick` pulse from the baud tick generator. It synchronises the asynchronous `rx` line, detects and validates the start bit, and samples each data bit and the stop bit at mid-bit. It presents each received character as a parallel word with a one-cycle `rx_done` strobe to the downstream RX FIFO. Frame format is 8N1 by default, with optional parity.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 151 +++++++++++++++
 tb/tb_uart_rx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the 16x-oversampling UART receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int         OVERSAMPLE  = 16;
  localparam logic [3:0] MID_SAMPLE  = 4'd7;
  localparam logic [3:0] LAST_SAMPLE = 4'd15;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} rx_state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} rx_state_t;
`endif

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser with a configurable reset value.
// Latency: 2 clk. Backpressure: none.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver, 8N1 default; UART_RX_PARITY_EN adds a parity bit.
// Latency: rx_done 1 clk after the mid-stop-bit tick. Backpressure: none, consumer must take each strobe.
import uart_pkg::*;

module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int         CNT_W    = $clog2(OVERSAMPLE);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rx_sync;
  logic                 rx_prev;
  logic                 fall;
  rx_state_t            state;
  logic [CNT_W-1:0]     tick_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_flag;

  sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_sync)
  );

  // Edge flop: a held-low line (break) never re-triggers a start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_prev <= 1'b1;
    else     rx_prev <= rx_sync;
  end

  assign fall = rx_prev & ~rx_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      par_flag  <= 1'b0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tick_cnt <= '0;
          if (fall) begin
            state   <= ST_START;
            rx_busy <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            if (tick_cnt == MID_SAMPLE) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              par_flag <= 1'b0;
              if (rx_sync) begin
                state   <= ST_IDLE;
                rx_busy <= 1'b0;
              end else begin
                state <= ST_DATA;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (tick_cnt == LAST_SAMPLE) begin
              tick_cnt <= '0;
              shreg    <= {rx_sync, shreg[DATA_BITS-1:1]};
              if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            if (tick_cnt == LAST_SAMPLE) begin
              tick_cnt <= '0;
              par_flag <= ((^shreg) ^ rx_sync) != PARITY_ODD[0];
              state    <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            // Return to IDLE at mid-stop so back-to-back frames tolerate baud skew.
            if (tick_cnt == LAST_SAMPLE) begin
              tick_cnt  <= '0;
              rx_data   <= shreg;
              frame_err <= ~rx_sync;
              rx_done   <= 1'b1;
              rx_busy   <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                     parity_err <= 1'b0;
    else if (state == ST_STOP && tick && tick_cnt == LAST_SAMPLE) parity_err <= par_flag;
  end
`else
  logic unused_parity;
  assign unused_parity = PARITY_ODD[0] ^ par_flag;
  assign parity_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected frames, a monitor pops on rx_done.
// Directed frames cover normal, back-to-back, glitch, framing error, mid-frame reset and break.
module tb_uart_rx;

  localparam int TICK_DIV = 4;
  localparam int BIT_CLK  = 16 * TICK_DIV;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       tick = 1'b0;
  logic       rx   = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;
  logic       parity_err;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  uart_rx #(.DATA_BITS(8), .PARITY_ODD(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    int div;
    div = 0;
    forever begin
      @(posedge clk);
      #1;
      tick = (div == TICK_DIV - 1);
      div  = (div + 1) % TICK_DIV;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_done === 1'b1) begin
        check("done_single_cycle", {31'd0, prev_done}, 32'd0);
        check("busy_low_at_done", {31'd0, rx_busy}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got data %0h expected no strobe", rx_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
          check("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
          check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
        end
      end
      prev_done = rx_done;
    end
  end

  task automatic expect_frame(input logic [7:0] d, input logic ferr, input logic perr);
    exp_t e;
    e.data = d;
    e.ferr = ferr;
    e.perr = perr;
    exp_q.push_back(e);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`else
    if (par_bit === 1'bx) $display("parity bit undefined");
`endif
    drive_bit(stop_bit);
  endtask

  initial begin : stimulus
    logic [7:0] d;
    repeat (5) @(posedge clk);
    #1;
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_rx_done", {31'd0, rx_done}, 32'd0);
    check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_parity_err", {31'd0, parity_err}, 32'd0);
    rst = 1'b0;
    idle_bits(1);

    expect_frame(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, ^8'hA5);
    idle_bits(2);

    expect_frame(8'h00, 1'b0, 1'b0);
    expect_frame(8'hFF, 1'b0, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle_bits(2);

    // Four-tick low pulse: START must reject it at the mid-start sample.
    rx = 1'b0;
    repeat (4 * TICK_DIV) @(posedge clk);
    #1;
    check("glitch_busy_high", {31'd0, rx_busy}, 32'd1);
    idle_bits(1);
    check("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
    expect_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle_bits(2);

    expect_frame(8'h5A, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0);
    idle_bits(2);
    expect_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0);
    idle_bits(2);

    // Reset in the middle of data bit 4 of 0xC3.
    d = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    repeat (BIT_CLK / 2) @(posedge clk);
    #1;
    check("midframe_busy_before_rst", {31'd0, rx_busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
    check("rst_rx_done", {31'd0, rx_done}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rx  = 1'b1;
    rst = 1'b0;
    idle_bits(3);
    expect_frame(8'h7E, 1'b0, 1'b0);
    send_frame(8'h7E, 1'b1, 1'b0);
    idle_bits(2);

    // Line break: exactly one all-zero frame with a framing error.
    expect_frame(8'h00, 1'b1, 1'b0);
    rx = 1'b0;
    repeat (12 * BIT_CLK) @(posedge clk);
    #1;
    check("break_busy_low", {31'd0, rx_busy}, 32'd0);
    idle_bits(2);

`ifdef UART_RX_PARITY_EN
    expect_frame(8'h01, 1'b0, 1'b0);
    send_frame(8'h01, 1'b1, 1'b1);
    idle_bits(2);
    expect_frame(8'h01, 1'b0, 1'b1);
    send_frame(8'h01, 1'b1, 1'b0);
    idle_bits(2);
`endif

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("all_frames_received", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
